// File: rtl/mem_apb_s.sv
// APB completer memory: byte-strobed writes, word reads, P_DELAY wait states,
// PSLVERR on accesses outside the address window.
// Ports: PCLK/PRESET (sync, active high), APB completer signals PSEL, PADDR,
//   PENABLE, PWRITE, PWDATA, PSTRB, PPROT in; PRDATA, PREADY, PSLVERR out.
module mem_apb_s #(
   parameter int          P_DWIDTH        = 32,
   parameter int          P_STRB          = P_DWIDTH / 8,
   parameter int          P_SIZE_IN_BYTES = 1024,
   parameter logic [31:0] P_ADDR_START    = 32'h0000_0000,
   parameter int          P_DELAY         = 0
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                PSEL,
   input  logic [31:0]         PADDR,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [P_DWIDTH-1:0] PWDATA,
   input  logic [P_STRB-1:0]   PSTRB,
   input  logic [2:0]          PPROT,
   output logic [P_DWIDTH-1:0] PRDATA,
   output logic                PREADY,
   output logic                PSLVERR
);

   localparam int LW    = $clog2(P_STRB);
   localparam int AW    = $clog2(P_SIZE_IN_BYTES);
   localparam int IW    = AW - LW;
   localparam int DEPTH = P_SIZE_IN_BYTES / P_STRB;
   localparam logic [3:0] DLY = 4'(P_DELAY);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACCESS = 1'b1;

   logic [P_DWIDTH-1:0] mem [DEPTH];

   logic [31:0]   offset;
   logic          hit;
   logic [IW-1:0] idx;
   logic          unused_bits;

   // Subtracting the base makes addresses below the window wrap high,
   // so a single unsigned compare covers both sides.
   assign offset      = PADDR - P_ADDR_START;
   assign hit         = offset < 32'(P_SIZE_IN_BYTES);
   assign idx         = offset[AW-1:LW];
   assign unused_bits = ^{PPROT, offset[LW-1:0]};

   logic [0:0]          state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                wr_q, wr_d;
   logic                hit_q, hit_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [P_DWIDTH-1:0] prdata_q, prdata_d;
   logic                pready_q, pready_d;
   logic                pslverr_q, pslverr_d;
   logic                mem_we;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_d      = wr_q;
      hit_d     = hit_q;
      cnt_d     = cnt_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      mem_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // PSEL with PENABLE but no setup phase is ignored here.
            if (PSEL && !PENABLE) begin
               idx_d     = idx;
               wr_d      = PWRITE;
               hit_d     = hit;
               cnt_d     = DLY;
               pready_d  = (DLY == 4'd0);
               pslverr_d = (DLY == 4'd0) && !hit;
               state_d   = S_ACCESS;
               if (!PWRITE) begin
                  prdata_d = hit ? mem[idx] : '0;
               end
            end
         end
         default: begin
            if (!PSEL) begin
               state_d   = S_IDLE;
               cnt_d     = 4'd0;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  pready_d  = 1'b1;
                  pslverr_d = !hit_q;
               end
            end else if (pready_q && PENABLE) begin
               mem_we    = wr_q && hit_q && !PRESET;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         hit_q     <= 1'b0;
         cnt_q     <= 4'd0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wr_q      <= wr_d;
         hit_q     <= hit_d;
         cnt_q     <= cnt_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   // Write data and strobes are taken on the completion edge.
   always_ff @(posedge PCLK) begin
      if (mem_we) begin
         for (int i = 0; i < P_STRB; i++) begin
            if (PSTRB[i]) begin
               mem[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
            end
         end
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_mem_apb_s.sv
// Directed bench for mem_apb_s: two instances, P_DELAY=0 and P_DELAY=3,
// sharing one APB bus with separate PSEL lines.
module tb_mem_apb_s;

   logic        clk = 1'b0;
   logic        preset = 1'b1;
   logic        psel0 = 1'b0;
   logic        psel3 = 1'b0;
   logic [31:0] paddr = '0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [2:0]  pprot = '0;

   logic [31:0] prdata0, prdata3;
   logic        pready0, pready3;
   logic        pslverr0, pslverr3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_apb_s #(.P_DELAY(0)) u0 (
      .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PADDR(paddr),
      .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
      .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata0),
      .PREADY(pready0), .PSLVERR(pslverr0)
   );

   mem_apb_s #(.P_DELAY(3)) u3 (
      .PCLK(clk), .PRESET(preset), .PSEL(psel3), .PADDR(paddr),
      .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
      .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata3),
      .PREADY(pready3), .PSLVERR(pslverr3)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts at #1 after an edge; leaves the bus idle after completion edge.
   task automatic xfer(input bit d3, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd, output logic er,
                       output int w);
      logic rdy;
      psel0   = !d3;
      psel3   = d3;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      pstrb   = st;
      tick();
      penable = 1'b1;
      w = 0;
      rdy = d3 ? pready3 : pready0;
      while (!rdy && w < 40) begin
         tick();
         w++;
         rdy = d3 ? pready3 : pready0;
      end
      check("xfer_ready", rdy, 1);
      rd = d3 ? prdata3 : prdata0;
      er = d3 ? pslverr3 : pslverr0;
      tick();
      psel0   = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          w;
      logic [31:0] exp_mem [4];

      tick();
      tick();
      check("rst_pready0", pready0, 0);
      check("rst_pslverr0", pslverr0, 0);
      check("rst_prdata0", prdata0, 0);
      check("rst_pready3", pready3, 0);
      preset = 1'b0;
      tick();

      // zero wait states, write then read
      xfer(0, 1, 32'h04, 32'h1234_5678, 4'hF, rd, er, w);
      check("t1_wr_err", er, 0);
      check("t1_wr_waits", w, 0);
      check("t1_idle_after", pready0, 0);
      xfer(0, 0, 32'h04, 32'h0, 4'h0, rd, er, w);
      check("t1_rd_data", rd, 32'h1234_5678);
      check("t1_rd_err", er, 0);
      check("t1_rd_waits", w, 0);

      // three wait states
      xfer(1, 1, 32'h08, 32'h0F0F_A5A5, 4'hF, rd, er, w);
      check("t2_wr_waits", w, 3);
      xfer(1, 0, 32'h08, 32'h0, 4'h0, rd, er, w);
      check("t2_rd_waits", w, 3);
      check("t2_rd_data", rd, 32'h0F0F_A5A5);
      check("t2_rd_err", er, 0);

      // partial strobes
      xfer(0, 1, 32'h10, 32'h1111_1111, 4'hF, rd, er, w);
      xfer(0, 1, 32'h10, 32'hAABB_CCDD, 4'b0101, rd, er, w);
      xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, w);
      check("t3_strb_data", rd, 32'h11BB_11DD);

      // zero strobes write nothing and give no error
      xfer(0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, er, w);
      check("t3_strb0_err", er, 0);
      xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, w);
      check("t3_strb0_data", rd, 32'h11BB_11DD);

      // out of window
      xfer(0, 1, 32'h00, 32'hCAFE_F00D, 4'hF, rd, er, w);
      xfer(0, 1, 32'h400, 32'hDEAD_BEEF, 4'hF, rd, er, w);
      check("t4_wr_err", er, 1);
      xfer(0, 0, 32'h400, 32'h0, 4'h0, rd, er, w);
      check("t4_rd_err", er, 1);
      check("t4_rd_data", rd, 32'h0);
      xfer(0, 0, 32'h000, 32'h0, 4'h0, rd, er, w);
      check("t4_mem_kept", rd, 32'hCAFE_F00D);
      check("t4_mem_err", er, 0);

      // back-to-back RAW then write-all/read-all
      for (int i = 0; i < 4; i++) begin
         exp_mem[i] = $urandom;
         xfer(0, 1, 32'(i * 4), exp_mem[i], 4'hF, rd, er, w);
         xfer(0, 0, 32'(i * 4), 32'h0, 4'h0, rd, er, w);
         check("t5_raw", rd, exp_mem[i]);
      end
      for (int i = 0; i < 4; i++) begin
         exp_mem[i] = $urandom;
         xfer(1, 1, 32'(i * 4), exp_mem[i], 4'hF, rd, er, w);
      end
      for (int i = 0; i < 4; i++) begin
         xfer(1, 0, 32'(i * 4), 32'h0, 4'h0, rd, er, w);
         check("t5_raawa", rd, exp_mem[i]);
      end

      // PSEL+PENABLE without setup phase is ignored
      psel0   = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = 32'h0;
      pwdata  = 32'h0;
      pstrb   = 4'hF;
      tick();
      check("nosetup_rdy_a", pready0, 0);
      tick();
      check("nosetup_rdy_b", pready0, 0);
      psel0   = 1'b0;
      penable = 1'b0;
      tick();

      // abort during wait states
      xfer(1, 1, 32'h24, 32'h1357_9BDF, 4'hF, rd, er, w);
      psel3   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h24;
      pwdata  = 32'hFFFF_FFFF;
      pstrb   = 4'hF;
      tick();
      penable = 1'b1;
      tick();
      psel3   = 1'b0;
      penable = 1'b0;
      tick();
      check("abort_rdy", pready3, 0);
      xfer(1, 0, 32'h24, 32'h0, 4'h0, rd, er, w);
      check("abort_mem", rd, 32'h1357_9BDF);

      // reset in 2nd wait cycle of a write
      xfer(1, 1, 32'h20, 32'h5555_AAAA, 4'hF, rd, er, w);
      psel3   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h20;
      pwdata  = 32'hDEAD_BEEF;
      pstrb   = 4'hF;
      tick();
      penable = 1'b1;
      tick();
      preset = 1'b1;
      tick();
      check("t6_rdy", pready3, 0);
      check("t6_err", pslverr3, 0);
      preset  = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
      tick();
      xfer(1, 0, 32'h20, 32'h0, 4'h0, rd, er, w);
      check("t6_mem", rd, 32'h5555_AAAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
